truth_table_checker: RTL
========================

Name: truth_table_checker

Overview:
- Sequential stimulus and response engine for the lab's small combinational gate-level circuits.
- Steps the circuit under test through every input combination and waits a programmable settle time after each one.
- Samples the circuit's single output into a captured truth table and compares that table with an expected one.
- Sits beside the device under test on the lab board or in simulation, driving its inputs and reading its output.

Parameters:
- N_IN, 3, number of circuit-under-test inputs; range 1..6.
- SETTLE_CYCLES, 4, clock cycles each vector is held before sampling; minimum 1.
- EXPECTED, 8'hE0, expected truth table, width 2**N_IN. Bit i is the expected output for vec_out == i, with the MSB input driven by vec_out[N_IN-1].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begins a sweep when sampled high in IDLE
- abort  input  1  terminates a running sweep; returns to IDLE without done
- f_in  input  1  output of the circuit under test
- vec_out  output  N_IN  input vector driven to the circuit under test
- busy  output  1  high from the cycle after start is accepted until the cycle done is asserted
- done  output  1  one-cycle pulse when a sweep completes
- pass  output  1  captured == EXPECTED; valid from done, held until next accepted start
- captured  output  2**N_IN  sampled truth table
- fail_count  output  N_IN+1  number of mismatching entries
- first_fail_idx  output  N_IN  lowest mismatching index; 0 if none
- fail_valid  output  1  at least one mismatch exists; valid with pass

Behaviour:
- Reset (async, rst_n low) sets:
  - state = IDLE
  - vec_out, captured, fail_count, first_fail_idx = 0
  - busy, done, pass, fail_valid = 0
- Reset release takes effect at the next clk edge. Reset mid-sweep discards all partial results.
- FSM states: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - On start=1: vec_out <= 0, cnt <= 0.
  - Clear captured, pass, fail_valid, fail_count and first_fail_idx.
  - busy <= 1, go to SETTLE.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYCLES-1, go to SAMPLE.
  - vec_out is held constant throughout.
- SAMPLE (one cycle):
  - captured[vec_out] <= f_in.
  - If f_in != EXPECTED[vec_out]: increment fail_count. If this is the first mismatch, set first_fail_idx <= vec_out and fail_valid <= 1.
  - If vec_out == 2**N_IN-1, go to FINISH. Otherwise vec_out <= vec_out+1, cnt <= 0, go to SETTLE.
- FINISH (one cycle):
  - done <= 1 for exactly one cycle, busy <= 0.
  - pass <= (fail_count == 0), go to IDLE.
  - vec_out returns to 0.
- Latency: done is asserted 2**N_IN*(SETTLE_CYCLES+1)+2 cycles after the start edge. That is 42 cycles at the defaults.
- start while busy is ignored.
- start and abort asserted in the same IDLE cycle: abort wins and start is ignored.
- abort in SETTLE or SAMPLE:
  - Go to IDLE next cycle with busy=0, vec_out=0, done never pulses.
  - captured and the fail fields keep their partial values.
  - pass stays 0.
- abort in FINISH is ignored; the sweep completes.
- vec_out changes only on the entry to SETTLE, never during a settle window.
- f_in is sampled directly with no synchronizer. SETTLE_CYCLES times the clock period must exceed the circuit's worst-case propagation delay.
- fail_count saturates by construction: its maximum value 2**N_IN fits in N_IN+1 bits.

Test Plan:
- Matching circuit: defaults, 10 ns clock, DUT f=ab+ac with 10 ns gate delays, pulse start → done at cycle 42, captured=8'hE0, pass=1, fail_count=0, fail_valid=0.
- Faulty circuit: f_in forced 0 throughout → captured=8'h00, pass=0, fail_count=3, first_fail_idx=5, fail_valid=1.
- Settle violation: SETTLE_CYCLES=1, 10 ns clock, DUT with 30 ns worst path → at least one mismatch reported, pass=0. This demonstrates the timing constraint.
- Abort: assert abort during vector 3 → busy drops next cycle, no done pulse, vec_out=0. A new start then completes normally with pass=1.
- Start ignored: pulse start again at cycle 10 of a sweep → done is still asserted exactly once, at cycle 42.
- Async reset: drop rst_n mid-cycle during vector 6 → all outputs go to 0 immediately, without waiting for a clock edge, and state returns to IDLE.

Source files
------------

// File: rtl/truth_table_checker.sv
// Sweeps every input combination of a small combinational circuit, waits a settle
// window per vector, captures its output into a truth table and scores it against EXPECTED.
module truth_table_checker #(
    parameter int N_IN = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'hE0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 f_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 fail_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]    FC_ONE   = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic [2**N_IN-1:0]  captured_q, captured_d;
    logic [N_IN:0]       fail_count_q, fail_count_d;
    logic [N_IN-1:0]     first_fail_q, first_fail_d;
    logic                fail_valid_q, fail_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                mismatch;

    // f_in is used unsynchronized; the settle window is what makes it stable here.
    assign mismatch = (f_in != EXPECTED[vec_q]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vec_d        = vec_q;
        captured_d   = captured_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    vec_d        = '0;
                    cnt_d        = '0;
                    captured_d   = '0;
                    pass_d       = 1'b0;
                    fail_valid_d = 1'b0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    busy_d       = 1'b1;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = SAMPLE;
                    end
                end
            end
            SAMPLE: begin
                // Abort takes priority over the sample that would have been taken this cycle.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else begin
                    captured_d[vec_q] = f_in;
                    if (mismatch) begin
                        fail_count_d = fail_count_q + FC_ONE;
                        if (!fail_valid_q) begin
                            first_fail_d = vec_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == VEC_LAST) begin
                        state_d = FINISH;
                    end else begin
                        vec_d   = vec_q + VEC_ONE;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (fail_count_q == '0);
                vec_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                vec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            vec_q        <= '0;
            captured_q   <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vec_q        <= vec_d;
            captured_q   <= captured_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign captured       = captured_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_q;
    assign fail_valid     = fail_valid_q;

endmodule
